// File: rtl/key_cpu_sel_pkg.sv
// Shared definitions for the CPU-select key path.
// Holds the debounce FSM state encodings and the default sizing of the
// core-select bus (kept alongside CpuNumWidth so cpu_top and this block agree).
package key_cpu_sel_pkg;

    localparam int CPU_NUM_WIDTH    = 2;
    localparam int CPU_NUM_DEF      = 4;
    localparam int SEL_W_DEF        = CPU_NUM_WIDTH;
    // 10 ms at 50 MHz
    localparam int DEBOUNCE_CYC_DEF = 500_000;

    typedef enum logic [1:0] {
        KS_IDLE         = 2'd0,
        KS_PRESS_WAIT   = 2'd1,
        KS_HELD         = 2'd2,
        KS_RELEASE_WAIT = 2'd3
    } key_state_e;

endpackage

// File: rtl/key_cpu_sel_if.sv
// Key / core-select bundle between the board button and the CPU-select logic.
//   key_in      raw button level (asynchronous, bouncy)
//   press_pulse one-cycle strobe per accepted press
//   sel         current CPU index
//   key_level   debounced key level
// master: the side that owns the button; slave: key_cpu_sel.
interface key_cpu_sel_if #(
    parameter int SEL_W = key_cpu_sel_pkg::SEL_W_DEF
);
    import key_cpu_sel_pkg::*;

    logic             key_in;
    logic             press_pulse;
    logic [SEL_W-1:0] sel;
    logic             key_level;

    modport master (output key_in, input press_pulse, input sel, input key_level);
    modport slave  (input key_in, output press_pulse, output sel, output key_level);

endinterface

// File: rtl/key_cpu_sel_sync_2ff.sv
// sync_2ff: two-flop synchroniser for asynchronous level inputs.
//   clk  destination clock
//   rst  asynchronous active-low reset, both stages clear to 0
//   d    asynchronous input (W bits, each bit synchronised independently)
//   q    synchronised output, two clk edges behind d
module sync_2ff #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] s1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1 <= '0;
            q  <= '0;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end

endmodule

// File: rtl/key_cpu_sel.sv
// key_cpu_sel: debounced push-button to wrapping CPU-select index.
//   clk  system clock
//   rst  asynchronous active-low reset
//   bus  key_cpu_sel_if slave: key_in in; press_pulse, sel, key_level out
//
// state            | meaning
// -----------------+----------------------------------------------------
// KS_IDLE          | key released and stable, waiting for key_s=1
// KS_PRESS_WAIT    | key_s high, counting stable cycles before accepting
// KS_HELD          | press accepted, waiting for key_s=0
// KS_RELEASE_WAIT  | key_s low, counting stable cycles before releasing
module key_cpu_sel
    import key_cpu_sel_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
    parameter int CPU_NUM      = CPU_NUM_DEF,
    parameter int SEL_W        = SEL_W_DEF
) (
    input logic          clk,
    input logic          rst,
    key_cpu_sel_if.slave bus
);

    localparam int                CNT_W    = $clog2(DEBOUNCE_CYC);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [SEL_W-1:0]  SEL_LAST = SEL_W'(CPU_NUM - 1);

    if (DEBOUNCE_CYC < 2) begin : g_bad_debounce
        $error("key_cpu_sel: DEBOUNCE_CYC must be at least 2");
    end
    if ((2 ** SEL_W) < CPU_NUM) begin : g_bad_sel_w
        $error("key_cpu_sel: SEL_W too narrow for CPU_NUM");
    end

    logic             key_s;
    key_state_e       state;
    logic [CNT_W-1:0] cnt;
    logic             pulse;
    logic [SEL_W-1:0] sel_cnt;
    logic             level;

    sync_2ff #(.W(1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (bus.key_in),
        .q   (key_s)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= KS_IDLE;
            cnt     <= '0;
            pulse   <= 1'b0;
            sel_cnt <= '0;
            level   <= 1'b0;
        end else begin
            pulse <= 1'b0;
            case (state)
                KS_IDLE: begin
                    level <= 1'b0;
                    if (key_s) begin
                        state <= KS_PRESS_WAIT;
                        cnt   <= '0;
                    end
                end
                KS_PRESS_WAIT: begin
                    if (!key_s) begin
                        state <= KS_IDLE;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        // pulse, sel and level all move on the edge that enters HELD
                        state   <= KS_HELD;
                        cnt     <= '0;
                        pulse   <= 1'b1;
                        level   <= 1'b1;
                        sel_cnt <= (sel_cnt == SEL_LAST) ? '0 : sel_cnt + 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                KS_HELD: begin
                    level <= 1'b1;
                    if (!key_s) begin
                        state <= KS_RELEASE_WAIT;
                        cnt   <= '0;
                    end
                end
                KS_RELEASE_WAIT: begin
                    if (key_s) begin
                        // release bounce: back to HELD without a new press
                        state <= KS_HELD;
                        cnt   <= '0;
                        level <= 1'b1;
                    end else if (cnt == CNT_LAST) begin
                        state <= KS_IDLE;
                        cnt   <= '0;
                        level <= 1'b0;
                    end else begin
                        cnt   <= cnt + 1'b1;
                        level <= 1'b1;
                    end
                end
                default: begin
                    state <= KS_IDLE;
                    cnt   <= '0;
                    level <= 1'b0;
                end
            endcase
        end
    end

    assign bus.press_pulse = pulse;
    assign bus.sel         = sel_cnt;
    assign bus.key_level   = level;

endmodule

// File: doc/key_cpu_sel.md
Name: key_cpu_sel

Overview:
- Upstream stage of the CPU-select counter feeding `cpu_top.key2`.
- Takes the raw board push-button and synchronises it to `clk`, then debounces it with a 4-state FSM.
- Emits one clean press pulse per physical press and maintains a wrapping CPU index for direct use as the core-select bus.
- Replaces the ad-hoc duration counter in the top level.

Parameters:
- DEBOUNCE_CYC, 500_000, cycles the synchronised key must stay stable before a press or release is accepted (10 ms at 50 MHz); must be >= 2.
- CPU_NUM, 4, number of selectable cores; `sel` counts 0..CPU_NUM-1.
- SEL_W, 2, width of `sel`; must satisfy 2^SEL_W >= CPU_NUM.

Ports:
- clk  in  1  system clock, 50 MHz domain.
- rst  in  1  asynchronous, active-low reset; clears all state immediately, independent of `clk`.
- key_in  in  1  raw button level, active-high, asynchronous to `clk`, bouncy.
- press_pulse  out  1  single-cycle strobe on each accepted press.
- sel  out  SEL_W  current CPU index; drives `cpu_top.key2`.
- key_level  out  1  debounced key level: 1 in HELD and RELEASE_WAIT, else 0.

Behaviour:
- **Reset values** (rst=0): sync flops 0, state IDLE, debounce counter 0, press_pulse 0, sel 0, key_level 0.
- **Synchroniser:** 2-flop chain, key_in -> s1 -> key_s; all FSM decisions use key_s only.
- **Debounce counter:** width clog2(DEBOUNCE_CYC), unsigned. Cleared on every state entry and never wraps.
- **IDLE:** key_s=1 -> PRESS_WAIT, counter 0.
- **PRESS_WAIT:**
  - key_s=0 -> IDLE (bounce rejected, no pulse).
  - Else, if counter==DEBOUNCE_CYC-1 -> HELD.
  - Else counter+1.
- **Entering HELD** (registered, same edge as the state change):
  - press_pulse=1 for exactly one cycle.
  - sel <= (sel==CPU_NUM-1) ? 0 : sel+1.
- **HELD:** key_s=0 -> RELEASE_WAIT, counter 0. No further pulses while held, regardless of duration.
- **RELEASE_WAIT:**
  - key_s=1 -> HELD, with no pulse and no sel change (release bounce).
  - Else, if counter==DEBOUNCE_CYC-1 -> IDLE.
  - Else counter+1.
- **Latency:** call edge 0 the first clk edge sampling key_in=1, with key_in held high thereafter. Then:
  - key_s=1 after edge 1.
  - PRESS_WAIT after edge 2.
  - press_pulse high in the cycle following edge DEBOUNCE_CYC+2; sel updates on that same edge.
- **Release timing:** IDLE is reached DEBOUNCE_CYC+2 edges after key_in is first sampled low. A new press is only accepted from IDLE.
- **press_pulse** is deasserted on every other edge; it is never high on two consecutive cycles.
- **Illegal state encodings** return to IDLE on the next edge; sel is unchanged.
- **Reset mid-operation** (any state, including the pulse cycle): all outputs return to reset values asynchronously. After deassertion the FSM starts from IDLE even if key_in is still high, so a held key then yields a fresh press after the full latency.
- Outputs are all registered; there are no combinational paths from key_in.

Decomposition:
- Shared package (`define.v` style, alongside CpuNumWidth):
  - state encodings KS_IDLE=2'd0, KS_PRESS_WAIT=2'd1, KS_HELD=2'd2, KS_RELEASE_WAIT=2'd3;
  - default DEBOUNCE_CYC;
  - CPU_NUM and SEL_W, tied to CpuNumWidth.
- One sub-module: sync_2ff (parameterised width, async active-low reset, reset value 0), reusable for uart rx.
- The FSM, debounce counter and sel counter stay in key_cpu_sel.

Test Plan:
- Clean press, DEBOUNCE_CYC=8, CPU_NUM=4: key_in 0->1 sampled at edge 0 and held for 30 cycles -> press_pulse high only in the cycle after edge 10; sel 0->1 on edge 10; key_level=1 from edge 10.
- Bounce reject: key_in high for 5 cycles, low for 3, then high and held -> exactly one press_pulse, 10 edges after the final rising sample; sel increments once.
- Release bounce: while in HELD, key_in low for 4 cycles then high again -> FSM returns to HELD; no pulse; sel unchanged; key_level stays 1.
- Wrap: five full press/release cycles from reset -> sel sequence 1,2,3,0,1; exactly five pulses.
- Reset mid-operation: assert rst low asynchronously in PRESS_WAIT and in the pulse cycle -> press_pulse, sel and key_level go to 0 immediately, with no clock edge needed. Release rst with key_in high -> pulse 10 edges after the first post-reset edge; sel=1.
- Held key: key_in high for 1000 cycles -> one pulse only; after release and DEBOUNCE_CYC+2 low edges, state is IDLE and key_level=0.
